saikoro_roll_ctrl: RTL and testbench

Upstream control stage for the 1-to-6 dice counter/lamp decoder. It converts a raw push-button into the counter's `enable` strobe.
- While the button is held, it emits a fast periodic one-cycle `enable`.
- On release, it decelerates over a fixed number of increasingly spaced pulses, stops, and flags `done` so the displayed face is final.
- Its `enable` output connects directly to the dice counter's `enable` input, on the same `ck`/`reset`.

---
 rtl/saikoro_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 39 +++
 rtl/saikoro_roll_ctrl.sv | 163 ++++++++++++++++
 tb/tb_saikoro_roll_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/saikoro_pkg.sv
// Shared types and constants for the dice roll controller.
// Holds the roll FSM state type, default timing values and the
// period counter width helper.
package saikoro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    SLOW = 2'd2,
    HOLD = 2'd3
  } roll_state_t;

  localparam int FAST_DIV_DEF   = 4;
  localparam int SLOW_STEPS_DEF = 3;
  localparam int SLOW_INC_DEF   = 2;
  localparam int DB_CYCLES_DEF  = 8;

  // Width of the period counter: must hold the longest deceleration period,
  // FAST_DIV + SLOW_STEPS*SLOW_INC, without wrapping.
  function automatic int div_width(input int fast_div, input int slow_steps,
                                   input int slow_inc);
    return $clog2(fast_div + slow_steps * slow_inc + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Level debouncer for the synchronized roll button.
// The accepted level follows the input only after the input has held a new
// value for DB_CYCLES consecutive cycles. Only built with ROLL_DEBOUNCE_EN.
module btn_debounce
  import saikoro_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic ck,
  input  logic reset,
  input  logic i_btn,
  output logic o_level
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Count consecutive cycles of disagreement; accept the new level on the last one.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (i_btn == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == P_LAST) begin
      r_cnt   <= '0;
      r_level <= i_btn;
    end else begin
      r_cnt   <= r_cnt + P_ONE;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/saikoro_roll_ctrl.sv
// Roll controller in front of the 1-to-6 dice counter.
// Turns the raw roll button into a fast periodic enable strobe while held,
// then decelerates over SLOW_STEPS widening pulses and flags done.
// Optional macro ROLL_DEBOUNCE_EN inserts btn_debounce after the synchronizer.
module saikoro_roll_ctrl
  import saikoro_pkg::*;
#(
  parameter int FAST_DIV   = FAST_DIV_DEF,
  parameter int SLOW_STEPS = SLOW_STEPS_DEF,
  parameter int SLOW_INC   = SLOW_INC_DEF,
  parameter int DB_CYCLES  = DB_CYCLES_DEF
) (
  input  logic ck,
  input  logic reset,
  input  logic btn,
  output logic enable,
  output logic rolling,
  output logic done
);

  localparam int DIV_W  = div_width(FAST_DIV, SLOW_STEPS, SLOW_INC);
  localparam int STEP_W = (SLOW_STEPS > 1) ? $clog2(SLOW_STEPS) : 1;

  localparam logic [DIV_W-1:0]  P_ONE        = DIV_W'(1);
  localparam logic [DIV_W-1:0]  P_FAST       = DIV_W'(FAST_DIV);
  localparam logic [DIV_W-1:0]  P_INC        = DIV_W'(SLOW_INC);
  localparam logic [DIV_W-1:0]  P_FIRST_SLOW = DIV_W'(FAST_DIV + SLOW_INC);
  localparam logic [STEP_W-1:0] P_STEP_ONE   = STEP_W'(1);
  localparam logic [STEP_W-1:0] P_LAST_STEP  = STEP_W'(SLOW_STEPS - 1);

  // Reject parameter sets that would make the period arithmetic meaningless.
  if (FAST_DIV < 1 || SLOW_STEPS < 1 || SLOW_INC < 0 || DB_CYCLES < 1) begin : g_param_check
    $error("saikoro_roll_ctrl: illegal parameter value");
  end

  logic              r_sync1;
  logic              r_sync2;
  logic              w_btn_s;
  logic              w_btn_lvl;
  roll_state_t       r_state;
  roll_state_t       w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [DIV_W-1:0]  r_period;
  logic [DIV_W-1:0]  w_period_nxt;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_nxt;
  logic              w_pulse;
  logic              r_enable;
  logic              r_rolling;
  logic              r_done;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = r_sync2;

`ifdef ROLL_DEBOUNCE_EN
  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .ck      (ck),
    .reset   (reset),
    .i_btn   (w_btn_s),
    .o_level (w_btn_lvl)
  );
`else
  assign w_btn_lvl = w_btn_s;
`endif

  // A pulse is due when the period counter reaches its last count.
  assign w_pulse = ((r_state == SPIN) || (r_state == SLOW)) &&
                   (r_div == (r_period - P_ONE));

  // Next-state, period and step selection; div restarts on every state entry.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = '0;
    w_period_nxt = r_period;
    w_step_nxt   = r_step;
    case (r_state)
      IDLE: begin
        if (w_btn_lvl) begin
          w_state_nxt  = SPIN;
          w_period_nxt = P_FAST;
        end
      end
      SPIN: begin
        w_div_nxt = w_pulse ? '0 : (r_div + P_ONE);
        if (!w_btn_lvl) begin
          w_state_nxt  = SLOW;
          w_div_nxt    = '0;
          w_step_nxt   = '0;
          w_period_nxt = P_FIRST_SLOW;
        end
      end
      SLOW: begin
        w_div_nxt = w_pulse ? '0 : (r_div + P_ONE);
        if (w_btn_lvl) begin
          // A re-press wins over a coincident final pulse.
          w_state_nxt  = SPIN;
          w_div_nxt    = '0;
          w_step_nxt   = '0;
          w_period_nxt = P_FAST;
        end else if (w_pulse) begin
          if (r_step == P_LAST_STEP) begin
            w_state_nxt = HOLD;
          end else begin
            w_step_nxt   = r_step + P_STEP_ONE;
            w_period_nxt = r_period + P_INC;
          end
        end
      end
      HOLD: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_period <= '0;
      r_step   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_period <= w_period_nxt;
      r_step   <= w_step_nxt;
    end
  end

  // Registered outputs, aligned with the state they describe.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_enable  <= 1'b0;
      r_rolling <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_enable  <= w_pulse;
      r_rolling <= (w_state_nxt == SPIN) || (w_state_nxt == SLOW);
      r_done    <= (w_state_nxt == HOLD);
    end
  end

  assign enable  = r_enable;
  assign rolling = r_rolling;
  assign done    = r_done;

endmodule

// File: tb/tb_saikoro_roll_ctrl.sv
// Scoreboard bench for saikoro_roll_ctrl: two instances (default timing and
// FAST_DIV=1/SLOW_STEPS=1/SLOW_INC=0) share the button and reset; a
// countdown-based reference model predicts every cycle's outputs.
module tb_saikoro_roll_ctrl;

  localparam int F0 = 4, N0 = 3, I0 = 2;
  localparam int F1 = 1, N1 = 1, I1 = 0;
  localparam int DB = 8;

  logic ck    = 1'b0;
  logic reset = 1'b1;
  logic btn   = 1'b0;
  logic en0, rol0, dn0;
  logic en1, rol1, dn1;

  saikoro_roll_ctrl #(
    .FAST_DIV(F0), .SLOW_STEPS(N0), .SLOW_INC(I0), .DB_CYCLES(DB)
  ) u_dut0 (
    .ck(ck), .reset(reset), .btn(btn),
    .enable(en0), .rolling(rol0), .done(dn0)
  );

  saikoro_roll_ctrl #(
    .FAST_DIV(F1), .SLOW_STEPS(N1), .SLOW_INC(I1), .DB_CYCLES(DB)
  ) u_dut1 (
    .ck(ck), .reset(reset), .btn(btn),
    .enable(en1), .rolling(rol1), .done(dn1)
  );

  always #5 ck = ~ck;

  // mode: 0 idle, 1 spinning, 2 slowing, 3 finished (done cycle)
  typedef struct {
    int   mode;
    int   left;
    int   period;
    int   npulse;
    int   run;
    logic s1;
    logic s2;
    logic lvl;
    logic en;
    logic rol;
    logic dn;
  } mdl_t;

  mdl_t       m0, m1;
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  int         checks   = 0;
  int         failures = 0;

  function automatic mdl_t mdl_step(input mdl_t m, input logic b, input logic rst,
                                    input int f, input int n, input int inc);
    mdl_t r;
    logic bin;
    logic pulse;
    r = m;
    pulse = 1'b0;
    if (rst) begin
      r = '{default: 0};
      return r;
    end
`ifdef ROLL_DEBOUNCE_EN
    bin = m.lvl;
    if (m.s2 == m.lvl) r.run = 0;
    else begin
      r.run = m.run + 1;
      if (r.run == DB) begin
        r.lvl = m.s2;
        r.run = 0;
      end
    end
`else
    bin = m.s2;
`endif
    r.s2 = m.s1;
    r.s1 = b;
    r.en = 1'b0;
    case (m.mode)
      0: if (bin) begin
        r.mode = 1; r.period = f; r.left = f;
      end
      1: begin
        r.left = m.left - 1;
        if (r.left == 0) begin
          r.en = 1'b1; r.left = m.period;
        end
        if (!bin) begin
          r.mode = 2; r.period = f + inc; r.left = f + inc; r.npulse = 0;
        end
      end
      2: begin
        r.left = m.left - 1;
        if (r.left == 0) begin
          pulse = 1'b1; r.en = 1'b1; r.npulse = m.npulse + 1;
          r.period = m.period + inc; r.left = r.period;
        end
        if (bin) begin
          r.mode = 1; r.period = f; r.left = f;
        end else if (pulse && r.npulse == n) begin
          r.mode = 3;
        end
      end
      default: r.mode = 0;
    endcase
    r.rol = (r.mode == 1) || (r.mode == 2);
    r.dn  = (r.mode == 3);
    return r;
  endfunction

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got{en,rol,done}=%b expected=%b", name, $time, got, exp);
    end
  endtask

  // Monitors: compare each instance's outputs away from the active edge.
  always @(negedge ck) begin
    if (q0.size() > 0) chk("dut0_outputs", {en0, rol0, dn0}, q0.pop_front());
  end

  always @(negedge ck) begin
    if (q1.size() > 0) chk("dut1_outputs", {en1, rol1, dn1}, q1.pop_front());
  end

  // One clock: the model consumes the inputs seen at this edge, then the
  // button is driven for the next edge.
  task automatic tick(input logic b);
    @(posedge ck);
    m0 = mdl_step(m0, btn, reset, F0, N0, I0);
    m1 = mdl_step(m1, btn, reset, F1, N1, I1);
    q0.push_back({m0.en, m0.rol, m0.dn});
    q1.push_back({m1.en, m1.rol, m1.dn});
    #1 btn = b;
  endtask

  task automatic hold(input logic b, input int n);
    repeat (n) tick(b);
  endtask

  // Mid-cycle asynchronous reset: outputs must clear at once.
  task automatic reset_pulse(input int n);
    reset = 1'b1;
    #1;
    chk("async_reset_dut0", {en0, rol0, dn0}, 3'b000);
    chk("async_reset_dut1", {en1, rol1, dn1}, 3'b000);
    q0[q0.size() - 1] = 3'b000;
    q1[q1.size() - 1] = 3'b000;
    hold(btn, n);
    reset = 1'b0;
  endtask

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    hold(1'b0, 3);
    reset = 1'b0;
    // Press, hold long enough to spin, release and let it settle.
    hold(1'b0, 6);
    hold(1'b1, 40);
    hold(1'b0, 50);
    // Re-press after the first slow pulse, then a full release.
    hold(1'b1, 20);
    hold(1'b0, 12);
    hold(1'b1, 20);
    hold(1'b0, 60);
    // Reset in the middle of deceleration.
    hold(1'b1, 20);
    hold(1'b0, 12);
    reset_pulse(3);
    hold(1'b0, 30);
    // Short glitch and a long press.
    hold(1'b1, 5);
    hold(1'b0, 25);
    hold(1'b1, 20);
    hold(1'b0, 60);
    // Short hold on the fast instance's timing.
    hold(1'b1, 5);
    hold(1'b0, 40);
    // Randomized presses, releases and occasional resets.
    for (int i = 0; i < 150; i++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 30));
      if ($urandom_range(0, 19) == 0) reset_pulse($urandom_range(1, 3));
    end
    hold(1'b0, 3);
    @(negedge ck);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
